multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Sequences the shared ALU, memory port, IR, PC and register file across the phases of each instruction.
- Drives the 2-bit aluop consumed by the ALU function decoder, plus all datapath mux selects and write enables.
- Adds a memready handshake so fetch and data accesses stretch for slow memory.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle MIPS core
// Optional BNE support: define MULTICYCLE_CTRL_BNE_EN
module multicycle_ctrl #(
  parameter logic [5:0] LW_OP    = 6'h23,
  parameter logic [5:0] SW_OP    = 6'h2B,
  parameter logic [5:0] RTYPE_OP = 6'h00,
  parameter logic [5:0] BEQ_OP   = 6'h04,
  parameter logic [5:0] ADDI_OP  = 6'h08,
  parameter logic [5:0] J_OP     = 6'h02,
  parameter logic [5:0] BNE_OP   = 6'h05
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [3:0] BNEEX   = 4'd12;

  logic [3:0] state_q, state_d;
  logic       pcwrite, branch, branchne;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state output decode; everything is forced low during reset
  always_comb begin
    state_d    = FETCH;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          LW_OP, SW_OP: state_d = MEMADR;
          RTYPE_OP:     state_d = RTYPEEX;
          BEQ_OP:       state_d = BEQEX;
          ADDI_OP:      state_d = ADDIEX;
          J_OP:         state_d = JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          BNE_OP:       state_d = BNEEX;
`else
          BNE_OP: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == LW_OP) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = memready;
        state_d    = memready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      BNEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branchne   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
    if (!reset) begin
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;
    end
    pcen = pcwrite | (branch & zero) | (branchne & ~zero);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memready;
  logic       memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, instr_done, illegal_op;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                     alusrcb, aluop, pcsrc, pcen, instr_done, illegal_op};

  function automatic logic [15:0] mk(input logic mw, input logic irw, input logic rw,
                                     input logic io, input logic m2r, input logic rd,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] ps,
                                     input logic pe, input logic dn, input logic il);
    return {mw, irw, rw, io, m2r, rd, asa, asb, aop, ps, pe, dn, il};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return mk(0, mr, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, mr, 0, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, ill);
  endfunction
  function automatic logic [15:0] e_memadr();
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_memrd();
    return mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_memwb();
    return mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_memwr(input logic mr);
    return mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, mr, 0);
  endfunction
  function automatic logic [15:0] e_rtex();
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_rtwb();
    return mk(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_branch(input logic pe);
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, pe, 1, 0);
  endfunction
  function automatic logic [15:0] e_addiex();
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_addiwb();
    return mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_jex();
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 1, 0);
  endfunction

  task automatic push_exp(input logic [15:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_check();
    logic [15:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests_run++;
    assert (obs === e) else begin
      tests_failed++;
      $error("FAIL %s: outputs=%b expected=%b", t, obs, e);
    end
  endtask

  // one clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1
  task automatic step(input logic [5:0] o, input logic z, input logic mr,
                      input logic [15:0] e, input string t);
    op = o;
    zero = z;
    memready = mr;
    push_exp(e, t);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    op = 6'h00;
    zero = 1'b0;
    memready = 1'b1;
    @(posedge clk);
    #1;
    step(6'h00, 0, 1, 16'h0000, "reset_hold0");
    step(6'h00, 0, 1, 16'h0000, "reset_hold1");
    reset = 1'b1;

    // R-type: 4 cycles
    step(6'h00, 0, 1, e_fetch(1), "rt_fetch");
    step(6'h00, 0, 1, e_decode(0), "rt_decode");
    step(6'h00, 0, 1, e_rtex(), "rt_ex");
    step(6'h00, 0, 1, e_rtwb(), "rt_wb");

    // lw with 2 fetch and 3 read wait states: 10 cycles
    step(6'h23, 0, 0, e_fetch(0), "lw_fetch_wait0");
    step(6'h23, 0, 0, e_fetch(0), "lw_fetch_wait1");
    step(6'h23, 0, 1, e_fetch(1), "lw_fetch");
    step(6'h23, 0, 1, e_decode(0), "lw_decode");
    step(6'h23, 0, 1, e_memadr(), "lw_memadr");
    step(6'h23, 0, 0, e_memrd(), "lw_memrd_wait0");
    step(6'h23, 0, 0, e_memrd(), "lw_memrd_wait1");
    step(6'h23, 0, 0, e_memrd(), "lw_memrd_wait2");
    step(6'h23, 0, 1, e_memrd(), "lw_memrd");
    step(6'h23, 0, 1, e_memwb(), "lw_memwb");

    // sw with one write wait state
    step(6'h2B, 0, 1, e_fetch(1), "sw_fetch");
    step(6'h2B, 0, 1, e_decode(0), "sw_decode");
    step(6'h2B, 0, 1, e_memadr(), "sw_memadr");
    step(6'h2B, 0, 0, e_memwr(0), "sw_memwr_wait");
    step(6'h2B, 0, 1, e_memwr(1), "sw_memwr");

    // addi, memready low where it must be ignored
    step(6'h08, 0, 1, e_fetch(1), "addi_fetch");
    step(6'h08, 0, 0, e_decode(0), "addi_decode_mr0");
    step(6'h08, 0, 0, e_addiex(), "addi_ex_mr0");
    step(6'h08, 0, 0, e_addiwb(), "addi_wb_mr0");

    // beq taken and not taken
    step(6'h04, 1, 1, e_fetch(1), "beq1_fetch");
    step(6'h04, 1, 1, e_decode(0), "beq1_decode");
    step(6'h04, 1, 1, e_branch(1), "beq_taken");
    step(6'h04, 0, 1, e_fetch(1), "beq0_fetch");
    step(6'h04, 0, 1, e_decode(0), "beq0_decode");
    step(6'h04, 0, 1, e_branch(0), "beq_not_taken");

    // jump
    step(6'h02, 0, 1, e_fetch(1), "j_fetch");
    step(6'h02, 0, 1, e_decode(0), "j_decode");
    step(6'h02, 0, 1, e_jex(), "j_ex");

    // bne opcode
    step(6'h05, 0, 1, e_fetch(1), "bne_fetch");
`ifdef MULTICYCLE_CTRL_BNE_EN
    step(6'h05, 0, 1, e_decode(0), "bne0_decode");
    step(6'h05, 0, 1, e_branch(1), "bne_taken");
    step(6'h05, 1, 1, e_fetch(1), "bne1_fetch");
    step(6'h05, 1, 1, e_decode(0), "bne1_decode");
    step(6'h05, 1, 1, e_branch(0), "bne_not_taken");
`else
    step(6'h05, 0, 1, e_decode(1), "bne_illegal");
`endif

    // unknown opcode: 2 cycles
    step(6'h3F, 0, 1, e_fetch(1), "ill_fetch");
    step(6'h3F, 0, 1, e_decode(1), "ill_decode");

    // reset asserted mid-RTYPEEX
    step(6'h00, 0, 1, e_fetch(1), "mid_fetch");
    step(6'h00, 0, 1, e_decode(0), "mid_decode");
    push_exp(e_rtex(), "mid_rtex");
    #1;
    pop_check();
    reset = 1'b0;
    push_exp(16'h0000, "mid_reset_immediate");
    #1;
    pop_check();
    @(posedge clk);
    #1;
    push_exp(16'h0000, "mid_reset_no_wb");
    pop_check();
    reset = 1'b1;
    step(6'h00, 0, 1, e_fetch(1), "post_reset_fetch");
    step(6'h00, 0, 1, e_decode(0), "post_reset_decode");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
